// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan driver.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV_HI = 2'd1,
    ST_CONV_LO = 2'd2,
    ST_COMMIT  = 2'd3
  } conv_state_t;

  localparam logic [7:0] FND_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_FONT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [7:0] font_of(input logic [3:0] d);
    logic [7:0] f;
    f = FND_OFF;
    if (d < 4'd10) f = SEG_FONT[d];
    return f;
  endfunction

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential subtract-by-10 splitter for two 0..99 values into tens/ones.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] hi,
  input  logic [6:0] lo,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens_hi,
  output logic [3:0] ones_hi,
  output logic [3:0] tens_lo,
  output logic [3:0] ones_lo
);

  conv_state_t state;
  logic [6:0]  rem_hi;
  logic [6:0]  rem_lo;
  logic [3:0]  t_hi;
  logic [3:0]  t_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rem_hi <= '0;
      rem_lo <= '0;
      t_hi   <= '0;
      t_lo   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_hi <= clamp99(hi);
            rem_lo <= clamp99(lo);
            t_hi   <= '0;
            t_lo   <= '0;
            state  <= ST_CONV_HI;
          end
        end
        ST_CONV_HI: begin
          if (rem_hi >= 7'd10) begin
            rem_hi <= rem_hi - 7'd10;
            t_hi   <= t_hi + 4'd1;
          end else begin
            state <= ST_CONV_LO;
          end
        end
        ST_CONV_LO: begin
          if (rem_lo >= 7'd10) begin
            rem_lo <= rem_lo - 7'd10;
            t_lo   <= t_lo + 4'd1;
          end else begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // busy stays high through COMMIT, so a load in that cycle is dropped
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_COMMIT);
  assign tens_hi = t_hi;
  assign ones_hi = rem_hi[3:0];
  assign tens_lo = t_lo;
  assign ones_lo = rem_lo[3:0];

endmodule

// File: rtl/fnd_scan_driver.sv
// Basys3 4-digit common-anode FND driver: scan, anti-ghost blanking, blink dot, LZ suppression.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] fnd_sel,
  input  logic       load,
  input  logic [6:0] value_hi,
  input  logic [6:0] value_lo,
  input  logic       blink_en,
  input  logic       lz_en,
  output logic       busy,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_font
);

  localparam logic [3:0]  BLANK_INIT = 4'(BLANK_CYCLES);
  localparam logic [25:0] BLINK_LAST = 26'(BLINK_CYCLES - 1);

  logic       conv_done;
  logic [3:0] c_tens_hi, c_ones_hi, c_tens_lo, c_ones_lo;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start   (load),
    .hi      (value_hi),
    .lo      (value_lo),
    .busy    (busy),
    .done    (conv_done),
    .tens_hi (c_tens_hi),
    .ones_hi (c_ones_hi),
    .tens_lo (c_tens_lo),
    .ones_lo (c_ones_lo)
  );

  logic [3:0]  d3, d2, d1, d0;
  logic [2:0]  prev_sel;
  logic [3:0]  blank_cnt;
  logic [3:0]  blank_next;
  logic [25:0] blink_cnt;
  logic        blink_ph;
  logic [1:0]  idx;
  logic [3:0]  cur_digit;
  logic [7:0]  font_next;
  logic [3:0]  com_next;

  assign idx = fnd_sel[1:0];

  always_comb begin
    blank_next = blank_cnt;
    if (fnd_sel != prev_sel) blank_next = BLANK_INIT;
    else if (blank_cnt != 4'd0) blank_next = blank_cnt - 4'd1;

    cur_digit = d0;
    case (idx)
      2'd0: cur_digit = d0;
      2'd1: cur_digit = d1;
      2'd2: cur_digit = d2;
      2'd3: cur_digit = d3;
      default: cur_digit = d0;
    endcase

    font_next = font_of(cur_digit);
    if (idx == 2'd3 && lz_en && d3 == 4'd0) font_next = FND_OFF;
    font_next[7] = !(idx == 2'd2 && blink_en && blink_ph);

    // Anodes are decided from the next blank count so BLANK_CYCLES=0 gives no gap
    com_next = (blank_next != 4'd0) ? COM_OFF : ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d3        <= '0;
      d2        <= '0;
      d1        <= '0;
      d0        <= '0;
      prev_sel  <= 3'b000;
      blank_cnt <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      fnd_com   <= COM_OFF;
      fnd_font  <= FND_OFF;
    end else begin
      prev_sel  <= fnd_sel;
      blank_cnt <= blank_next;
      fnd_com   <= com_next;
      fnd_font  <= font_next;
      if (conv_done) begin
        d3 <= c_tens_hi;
        d2 <= c_ones_hi;
        d1 <= c_tens_lo;
        d0 <= c_ones_lo;
      end
      if (!blink_en) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 26'd1;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed self-checking bench for fnd_scan_driver (BLANK_CYCLES=4, BLINK_CYCLES=4).
module tb_fnd_scan_driver;

  localparam int BLANK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] fnd_sel = 3'd0;
  logic       load = 1'b0;
  logic [6:0] value_hi = 7'd0;
  logic [6:0] value_lo = 7'd0;
  logic       blink_en = 1'b0;
  logic       lz_en = 1'b0;
  logic       busy;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;

  int n_checks = 0;
  int n_pass   = 0;

  fnd_scan_driver #(.BLANK_CYCLES(BLANK), .BLINK_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fnd_sel  (fnd_sel),
    .load     (load),
    .value_hi (value_hi),
    .value_lo (value_lo),
    .blink_en (blink_en),
    .lz_en    (lz_en),
    .busy     (busy),
    .fnd_com  (fnd_com),
    .fnd_font (fnd_font)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Move to a new select value, verify the blank window, then the lit anode and font
  task automatic scan_to(input logic [2:0] sel, input logic [7:0] exp_font);
    logic [3:0] exp_com;
    exp_com = ~(4'b0001 << sel[1:0]);
    fnd_sel = sel;
    tick(1);
    check("scan_blank_com", {28'd0, fnd_com}, 32'hF);
    tick(BLANK);
    check("scan_com", {28'd0, fnd_com}, {28'd0, exp_com});
    check("scan_font", {24'd0, fnd_font}, {24'd0, exp_font});
  endtask

  task automatic do_load(input logic [6:0] hi, input logic [6:0] lo, input int exp_busy);
    int cnt;
    value_hi = hi;
    value_lo = lo;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("busy_cycles", cnt, exp_busy);
  endtask

  initial begin
    int cnt;
    logic [7:0] exp_f;

    // Reset held: outputs off regardless of fnd_sel
    tick(2);
    fnd_sel = 3'd5;
    tick(1);
    check("rst_com", {28'd0, fnd_com}, 32'hF);
    check("rst_font", {24'd0, fnd_font}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    fnd_sel = 3'd2;
    tick(1);
    check("rst_com2", {28'd0, fnd_com}, 32'hF);

    // Release with fnd_sel equal to the reset previous-sel value
    fnd_sel = 3'd0;
    rst = 1'b1;
    tick(1);
    check("rel_com", {28'd0, fnd_com}, 32'hE);
    check("rel_font", {24'd0, fnd_font}, 32'hC0);

    // 59,7: 5 subtract steps + hi/lo transitions + commit
    do_load(7'd59, 7'd7, 8);
    scan_to(3'd3, 8'h92);
    scan_to(3'd2, 8'h90);
    scan_to(3'd1, 8'hC0);
    scan_to(3'd0, 8'hF8);

    // Blank window is exactly BLANK cycles wide
    fnd_sel = 3'd1;
    for (int i = 0; i < BLANK; i++) begin
      tick(1);
      check("blank_win", {28'd0, fnd_com}, 32'hF);
    end
    tick(1);
    check("blank_end", {28'd0, fnd_com}, 32'hD);

    // Clamp 120 -> 99, worst case; loads mid-busy and during COMMIT are dropped
    value_hi = 7'd120;
    value_lo = 7'd99;
    load = 1'b1;
    tick(1);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 5 || cnt == 20) begin
        load = 1'b1;
        value_hi = 7'd11;
        value_lo = 7'd22;
      end else begin
        load = 1'b0;
      end
      tick(1);
      cnt++;
    end
    load = 1'b0;
    check("busy_worst", cnt, 21);
    tick(1);
    check("busy_after_commit_load", {31'd0, busy}, 32'd0);
    scan_to(3'd3, 8'h90);
    scan_to(3'd2, 8'h90);
    scan_to(3'd1, 8'h90);
    scan_to(3'd0, 8'h90);

    // Leading-zero suppression
    lz_en = 1'b1;
    do_load(7'd5, 7'd0, 3);
    scan_to(3'd3, 8'hFF);
    scan_to(3'd2, 8'h92);
    lz_en = 1'b0;
    scan_to(3'd3, 8'hC0);

    // Blink dot on digit 2, phase toggles every 4 cycles
    scan_to(3'd2, 8'h92);
    blink_en = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      exp_f = (((i - 1) / 4) % 2 == 1) ? 8'h12 : 8'h92;
      check("blink_font", {24'd0, fnd_font}, {24'd0, exp_f});
    end
    blink_en = 1'b0;
    tick(1);
    check("blink_off", {24'd0, fnd_font}, 32'h92);

    // Reset mid-conversion aborts and clears digits
    value_hi = 7'd99;
    value_lo = 7'd99;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_com", {28'd0, fnd_com}, 32'hF);
    check("abort_font", {24'd0, fnd_font}, 32'hFF);
    tick(1);
    rst = 1'b1;
    scan_to(3'd3, 8'hC0);
    scan_to(3'd0, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
